// File: rtl/w5300_pkg.sv
// Shared definitions for the W5300 register-port arbiter: caddr field encoding,
// field widths and the arbiter state type.
package w5300_pkg;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 16;
  localparam int CADDR_W = ADDR_W + 2;

  localparam logic ADDR_OP_RD      = 1'b1;
  localparam logic ADDR_OP_WR      = 1'b0;
  localparam logic ADDR_S_VALID    = 1'b0;
  localparam logic ADDR_S_INVALID  = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } arb_state_t;

  function automatic logic [CADDR_W-1:0] make_caddr(input logic sel_n, input logic op,
                                                    input logic [ADDR_W-1:0] addr);
    return {sel_n, op, addr};
  endfunction

endpackage

// File: rtl/w5300_rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or after ptr,
// wrapping at N-1 -> 0. Returns a one-hot pick and a found flag.
module w5300_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         pick,
  output logic                 found
);

  localparam int IW = $clog2(N);
  localparam int SW = IW + 1;

  logic [SW-1:0] pos;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < N and k < N, so one conditional subtract is a full modulo
      pos = {1'b0, ptr} + SW'(k);
      if (pos >= SW'(N)) pos = pos - SW'(N);
      if (!found && req[pos[IW-1:0]]) begin
        pick[pos[IW-1:0]] = 1'b1;
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/w5300_bus_arbiter.sv
// Round-robin arbiter sharing the W5300 register port between N_REQ engines.
// Define W5300_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles.
module w5300_bus_arbiter
  import w5300_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_rd,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [CADDR_W-1:0]        caddr,
  output logic [DATA_W-1:0]         wr_data,
  input  logic                      op_status,
  input  logic [DATA_W-1:0]         rd_data
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("w5300_bus_arbiter: unsupported N_REQ or TIMEOUT_CYCLES");
  end

  arb_state_t          state, state_nxt;
  logic [IW-1:0]       ptr, ptr_nxt, owner, owner_nxt, pick_idx, sel;
  logic [N_REQ-1:0]    pick, gnt_nxt, done_nxt;
  logic                found, rsp_err_nxt, tmo_hit;
  logic [CADDR_W-1:0]  caddr_nxt, ld_caddr;
  logic [DATA_W-1:0]   wr_data_nxt, rsp_data_nxt, ld_wdata;
  logic [ADDR_W-1:0]   ld_addr;

  w5300_rr_pick #(.N(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .pick  (pick),
    .found (found)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick[i]) pick_idx = IW'(i);
  end

  // Fields are loaded for a fresh pick in IDLE or for the owner on a locked re-issue
  always_comb begin
    sel      = (state == ARB_DONE) ? owner : pick_idx;
    ld_addr  = '0;
    ld_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == sel) begin
        ld_addr  = req_addr[i*ADDR_W +: ADDR_W];
        ld_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
    ld_caddr = make_caddr(ADDR_S_VALID, req_rd[sel] ? ADDR_OP_RD : ADDR_OP_WR, ld_addr);
  end

`ifdef W5300_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          tmo_cnt <= '0;
    else if (state_nxt == ARB_ISSUE)  tmo_cnt <= '0;
    else if (state == ARB_WAIT)       tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == ARB_WAIT) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    owner_nxt    = owner;
    gnt_nxt      = gnt;
    done_nxt     = '0;
    caddr_nxt    = caddr;
    wr_data_nxt  = wr_data;
    rsp_data_nxt = rsp_data;
    rsp_err_nxt  = rsp_err;
    case (state)
      ARB_IDLE: begin
        caddr_nxt[CADDR_W-1] = ADDR_S_INVALID;
        if (found) begin
          owner_nxt   = pick_idx;
          gnt_nxt     = pick;
          caddr_nxt   = ld_caddr;
          wr_data_nxt = ld_wdata;
          state_nxt   = ARB_ISSUE;
        end
      end
      // op_status may still be high from the previous access; never sampled here
      ARB_ISSUE: state_nxt = ARB_WAIT;
      ARB_WAIT: begin
        if (op_status || tmo_hit) begin
          done_nxt             = gnt;
          rsp_data_nxt         = op_status ? rd_data : '0;
          rsp_err_nxt          = !op_status;
          caddr_nxt[CADDR_W-1] = ADDR_S_INVALID;
          state_nxt            = ARB_DONE;
        end
      end
      ARB_DONE: begin
        if (!rsp_err && req_lock[owner] && req[owner]) begin
          caddr_nxt   = ld_caddr;
          wr_data_nxt = ld_wdata;
          state_nxt   = ARB_ISSUE;
        end else begin
          gnt_nxt   = '0;
          ptr_nxt   = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      ptr      <= '0;
      owner    <= '0;
      gnt      <= '0;
      done     <= '0;
      caddr    <= make_caddr(ADDR_S_INVALID, ADDR_OP_RD, '0);
      wr_data  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      gnt      <= gnt_nxt;
      done     <= done_nxt;
      caddr    <= caddr_nxt;
      wr_data  <= wr_data_nxt;
      rsp_data <= rsp_data_nxt;
      rsp_err  <= rsp_err_nxt;
    end
  end

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Bench for w5300_bus_arbiter: table-driven single accesses, hand-written corner
// sequences and a random run, all checked against a transaction-timing model.
module tb_w5300_bus_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0, req_rd = '0, req_lock = '0;
  logic [N*10-1:0] req_addr = '0;
  logic [N*16-1:0] req_wdata = '0;
  logic [N-1:0]    gnt, done;
  logic [15:0]     rsp_data, wr_data;
  logic            rsp_err;
  logic [11:0]     caddr;
  logic            op_status = 1'b0;
  logic [15:0]     rd_data = '0;

  always #5 clk = ~clk;

  w5300_bus_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rd(req_rd), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .caddr(caddr), .wr_data(wr_data),
    .op_status(op_status), .rd_data(rd_data)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: owner (-1 = none), cycle its grant/issue became visible, cycle its done showed
  int          m_own = -1, m_g = 0, m_d = -1, m_ptr = 0;
  logic [10:0] m_ca = '0;
  logic [15:0] m_wd = '0, m_rsp = '0;
  logic        m_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_d = -1; m_ptr = 0; m_rsp = '0; m_err = 1'b0; cyc = 0;
  endtask

  task automatic tick();
    logic [N-1:0]    r, rl, rr;
    logic [N*10-1:0] ra;
    logic [N*16-1:0] rw;
    logic            op;
    logic [15:0]     rdat, e_ca;
    logic [N-1:0]    e_g, e_d;
    int              c, p;
    r = req; rl = req_lock; rr = req_rd; ra = req_addr; rw = req_wdata;
    op = op_status; rdat = rd_data; c = cyc;
    @(posedge clk); #1; cyc++;
    if (m_own < 0) begin
      p = -1;
      for (int j = 0; j < N; j++) if (p < 0 && r[(m_ptr + j) % N]) p = (m_ptr + j) % N;
      if (p >= 0) begin
        m_own = p; m_g = cyc; m_d = -1;
        m_ca = {rr[p], ra[p*10 +: 10]}; m_wd = rw[p*16 +: 16];
      end
    end else if (m_d < 0) begin
      if (c >= m_g + 1 && op) begin
        m_d = cyc; m_rsp = rdat; m_err = 1'b0;
      end
`ifdef W5300_ARB_TIMEOUT_EN
      else if (c == m_g + TMO) begin
        m_d = cyc; m_rsp = '0; m_err = 1'b1;
      end
`endif
    end else begin
      if (!m_err && rl[m_own] && r[m_own]) begin
        m_g = cyc; m_d = -1;
        m_ca = {rr[m_own], ra[m_own*10 +: 10]}; m_wd = rw[m_own*16 +: 16];
      end else begin
        m_ptr = (m_own + 1) % N; m_own = -1;
      end
    end
    e_g = (m_own >= 0) ? N'(1 << m_own) : '0;
    e_d = (m_own >= 0 && m_d == cyc) ? N'(1 << m_own) : '0;
    chk("gnt", 32'(gnt), 32'(e_g));
    chk("done", 32'(done), 32'(e_d));
    chk("sel_n", 32'(caddr[11]), 32'(!(m_own >= 0 && m_d < 0)));
    chk("rsp_data", 32'(rsp_data), 32'(m_rsp));
    chk("rsp_err", 32'(rsp_err), 32'(m_err));
    if (m_own >= 0 && m_d < 0) begin
      e_ca = {5'b0, m_ca};
      chk("caddr", 32'(caddr[10:0]), 32'(e_ca));
      chk("wr_data", 32'(wr_data), 32'(m_wd));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_lock = '0; op_status = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst_caddr", 32'(caddr), 32'h0000_0C00);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
  endtask

  typedef struct {
    int          idx;
    logic        rd;
    logic [9:0]  addr;
    logic [15:0] wd;
    int          delay;
    logic [15:0] rdat;
    logic [11:0] exp_caddr;
    int          exp_lat;
  } vec_t;

  vec_t vecs[4];
  int   order[$];
  int   issue_cyc[$];
  int   dcount[N];

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, n, idx, vcnt, n1;
    logic [N-1:0] prev_g;

    vecs[0] = '{1, 1'b1, 10'h224, 16'h0000, 3, 16'h1234, 12'h624, 5};
    vecs[1] = '{0, 1'b0, 10'h22e, 16'hBEEF, 0, 16'h5555, 12'h22e, 2};
    vecs[2] = '{3, 1'b1, 10'h3ff, 16'h0000, 1, 16'hA5A5, 12'h7ff, 3};
    vecs[3] = '{2, 1'b0, 10'h001, 16'h0F0F, 6, 16'hFFFF, 12'h001, 8};

    // Single accesses from idle; vecs[0] is the 0x224 read completing at cycle 6
    do_reset();
    foreach (vecs[v]) begin
      req = '0;
      req[vecs[v].idx] = 1'b1;
      req_rd[vecs[v].idx] = vecs[v].rd;
      req_addr[vecs[v].idx*10 +: 10] = vecs[v].addr;
      req_wdata[vecs[v].idx*16 +: 16] = vecs[v].wd;
      op_status = 1'b0;
      tick();
      g = cyc;
      chk("vec_caddr", 32'(caddr), 32'(vecs[v].exp_caddr));
      chk("vec_wdata", 32'(wr_data), 32'(vecs[v].wd));
      req = '0;
      rd_data = ~vecs[v].rdat;
      tick();
      for (int d = 0; d < vecs[v].delay; d++) tick();
      op_status = 1'b1;
      rd_data = vecs[v].rdat;
      n = 0;
      tick();
      while (done == '0 && n < 20) begin tick(); n++; end
      chk("vec_latency", 32'(cyc - g), 32'(vecs[v].exp_lat));
      chk("vec_rsp_data", 32'(rsp_data), 32'(vecs[v].rdat));
      op_status = 1'b0;
      rd_data = 16'(
        $urandom);
      tick();
    end

    // Contention 0/2/3 with op_status stuck high: order 0,2,3, done 2 cycles after grant
    do_reset();
    op_status = 1'b1;
    req = 4'b1101;
    prev_g = '0; g = 0;
    order.delete();
    for (int i = 0; i < N; i++) dcount[i] = 0;
    for (int t = 0; t < 40 && (req != '0 || gnt != '0); t++) begin
      rd_data = 16'($urandom);
      tick();
      if (gnt != '0 && gnt != prev_g) begin order.push_back(oh2i(gnt)); g = cyc; end
      if (done != '0) begin
        idx = oh2i(done);
        dcount[idx]++;
        chk("stale_done_lat", 32'(cyc - g), 32'd2);
        req[idx] = 1'b0;
      end
      prev_g = gnt;
    end
    chk("cont_grants", 32'(order.size()), 32'd3);
    if (order.size() == 3) begin
      chk("cont_first", 32'(order[0]), 32'd0);
      chk("cont_second", 32'(order[1]), 32'd2);
      chk("cont_third", 32'(order[2]), 32'd3);
    end
    chk("cont_done0", 32'(dcount[0]), 32'd1);
    chk("cont_done2", 32'(dcount[2]), 32'd1);
    chk("cont_done3", 32'(dcount[3]), 32'd1);
    req = 4'b0011;
    tick();
    chk("cont_ptr_wrap", 32'(gnt), 32'h1);
    req = '0;
    for (int t = 0; t < 4; t++) tick();

    // Locked burst of 3 writes by requester 1 while requester 0 waits
    do_reset();
    op_status = 1'b0;
    req_addr[10 +: 10] = 10'h22e; req_rd[1] = 1'b0; req_wdata[16 +: 16] = 16'h1000;
    req_addr[0 +: 10] = 10'h100; req_rd[0] = 1'b1;
    req_lock = 4'b0010;
    req = 4'b0010;
    vcnt = 0; n1 = 0;
    order.delete(); issue_cyc.delete();
    for (int t = 0; t < 60 && (req != '0 || gnt != '0); t++) begin
      op_status = (vcnt >= 3);
      rd_data = 16'($urandom);
      tick();
      if (t == 0) req[0] = 1'b1;
      if (caddr[11] == 1'b0) begin
        vcnt++;
        if (vcnt == 1) begin order.push_back(oh2i(gnt)); issue_cyc.push_back(cyc); end
      end else vcnt = 0;
      if (done[1]) begin
        n1++;
        req_wdata[16 +: 16] = req_wdata[16 +: 16] + 16'h1;
        if (n1 == 3) begin req[1] = 1'b0; req_lock[1] = 1'b0; end
      end
      if (done[0]) req[0] = 1'b0;
    end
    chk("lock_issues", 32'(order.size()), 32'd4);
    if (order.size() == 4) begin
      chk("lock_own_a", 32'(order[0]), 32'd1);
      chk("lock_own_b", 32'(order[1]), 32'd1);
      chk("lock_own_c", 32'(order[2]), 32'd1);
      chk("lock_own_d", 32'(order[3]), 32'd0);
      chk("lock_gap_1", 32'(issue_cyc[1] - issue_cyc[0]), 32'd4);
      chk("lock_gap_2", 32'(issue_cyc[2] - issue_cyc[1]), 32'd4);
    end

`ifdef W5300_ARB_TIMEOUT_EN
    // Driver never answers: error completion after TMO WAIT cycles, lock ignored
    do_reset();
    op_status = 1'b0;
    req_lock = 4'b0100; req_rd[2] = 1'b1; req = 4'b0100;
    tick();
    g = cyc;
    n = 0;
    while (done == '0 && n < 30) begin tick(); n++; end
    chk("tmo_latency", 32'(cyc - g), 32'(TMO + 1));
    chk("tmo_err", 32'(rsp_err), 32'h1);
    chk("tmo_data", 32'(rsp_data), 32'h0);
    req = '0; req_lock = '0;
    tick();
    chk("tmo_release", 32'(gnt), 32'h0);
    tick();
`endif

    // Asynchronous reset in the middle of WAIT
    do_reset();
    op_status = 1'b0;
    req = 4'b0010;
    tick();
    req = 4'b1000;
    tick(); tick();
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_caddr", 32'(caddr), 32'h0000_0C00);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    tick();
    chk("post_rst_grant", 32'(gnt), 32'h8);
    req = '0;
    op_status = 1'b1;
    for (int t = 0; t < 5; t++) tick();

    // Random traffic against the model
    op_status = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
        req_lock[i] = ($urandom_range(0, 5) == 0);
        req_rd[i] = 1'($urandom);
        req_addr[i*10 +: 10] = 10'($urandom);
        req_wdata[i*16 +: 16] = 16'($urandom);
      end
      op_status = ($urandom_range(0, 2) == 0);
      rd_data = 16'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
